fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//  Producer end of the instruction-word interface that the decode stage consumes.
//  Generates sequential fetch addresses and issues them to a fixed 1-cycle-latency instruction memory.
//  Buffers the returned words with their PC in a small FIFO.
//  Presents them to decode over a valid/ready handshake; flushes and refetches on a control-flow redirect.
// PARAMETERS
//  DEPTH     4             FIFO entries (power of two, >=2)
//  RESET_PC  32'hBFC0_0000 fetch address after reset
// PORTS
//  clk           in   1   single clock; all state updates on posedge
//  reset_n       in   1   synchronous, active-low reset
//  imem_req      out  1   fetch request this cycle
//  imem_addr     out  32  fetch address (valid when imem_req=1)
//  imem_rvalid   in   1   response valid; asserted exactly 1 cycle after imem_req
//  imem_rdata    in   32  instruction word (valid when imem_rvalid=1)
//  redirect      in   1   flush and refetch from redirect_pc (jump/branch/exception)
//  redirect_pc   in   32  new fetch address
//  dec_valid     out  1   head entry available to decode
//  dec_ready     in   1   decode accepts head this cycle
//  dec_instr     out  32  head instruction word (0 for an address-error entry)
//  dec_pc        out  32  head PC
//  dec_adel      out  1   head is a fetch address-error entry (pc[1:0]!=0)
// BEHAVIOUR
//  Reset (reset_n=0 at posedge):
//   - fetch_pc<=RESET_PC; FIFO empty; inflight<=0; halt<=0.
//   - While reset_n=0: imem_req=0, dec_valid=0, dec_instr=0, dec_pc=0, dec_adel=0.
//   - Reset mid-operation discards all entries and any in-flight response.
//  State:
//   - fetch_pc; FIFO {instr,pc,adel} x DEPTH with wrapping rd/wr ptrs and count (0..DEPTH);
//   - inflight (request issued last cycle, not killed); halt.
//  Request rule:
//   - imem_req = reset_n & !redirect & !halt & fetch_pc[1:0]==0 & (count+inflight < DEPTH).
//   - Same-cycle pop is NOT credited (conservative).
//   - imem_addr=fetch_pc. On imem_req: fetch_pc<=fetch_pc+4 (32-bit wrap), inflight<=1, else inflight<=0.
//  Response:
//   - If imem_rvalid & inflight: push {imem_rdata,fetch_pc-of-request,0}.
//   - Keep a registered copy of the request PC for this.
//   - imem_rvalid without inflight (killed) is ignored.
//  Misaligned fetch_pc:
//   - If !halt & !redirect & fetch_pc[1:0]!=0 & count+inflight<DEPTH: push {0,fetch_pc,1}, halt<=1, no imem_req.
//   - Halt holds until redirect or reset.
//  Decode side:
//   - dec_valid = count!=0; outputs show the head entry, registered FIFO storage.
//   - Pop when dec_valid&dec_ready.
//   - Push and pop in the same cycle are both honoured (count unchanged).
//   - Overflow cannot occur by construction; an assertion checks count<=DEPTH.
//   - Head outputs hold stable while dec_valid=1 & dec_ready=0.
//  Redirect (highest priority after reset):
//   - Effects at that edge: FIFO emptied (pop/push ignored), inflight<=0, the response arriving next cycle is dropped.
//   - Also fetch_pc<=redirect_pc, halt<=0, imem_req=0 that cycle.
//  Latency:
//   - Request in cycle N -> response in N+1 -> dec_valid in N+2.
//   - Sustained throughput of 1 instr/cycle with dec_ready=1.
//   - After redirect in cycle R: first request in R+1, dec_valid in R+3.
//  Ordering: decode sees PCs in strictly increasing +4 order between redirects, no loss, no duplicates.
// TESTING
//  1. Reset, dec_ready=1, rdata=addr^32'hFFFF_FFFF -> dec_pc BFC00000,BFC00004,... one per cycle from cycle 2, instr matches.
//  2. dec_ready=0 for 10 cycles -> exactly 4 imem_req issued, then none. Release -> 4 entries drain in order, fetch resumes, no dup/loss.
//  3. redirect to 0x80000100 in the cycle after a req -> stale rvalid dropped. Next dec_pc=0x80000100 at R+3.
//  4. redirect to 0x80000102 -> no imem_req. One entry pc=0x80000102 adel=1 instr=0, then idle until redirect to 0x80000200.
//  5. FIFO full, reset_n=0 for 1 cycle -> dec_valid=0 next cycle. First imem_addr after release = BFC00000.
//  6. dec_valid=1, dec_ready=1 and redirect same cycle -> head discarded, count=0 next cycle, no extra pop later.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: sequential instruction fetcher feeding decode through a small PC-tagged FIFO
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  output logic        dec_adel
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  logic [31:0]   fetch_pc_q, fetch_pc_d, req_pc_q, req_pc_d;
  logic          inflight_q, inflight_d, halt_q, halt_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   instr_q [DEPTH];
  logic [31:0]   instr_d [DEPTH];
  logic [31:0]   pc_q [DEPTH];
  logic [31:0]   pc_d [DEPTH];
  logic          adel_q [DEPTH];
  logic          adel_d [DEPTH];
  logic          can_fetch, resp_push, adel_push, push, pop;
  // Fetch permission (no credit for a same-cycle pop) and decode-facing head view
  always_comb begin
    can_fetch = reset_n & ~redirect & ~halt_q &
                (({1'b0, count_q} + {{CW{1'b0}}, inflight_q}) < {1'b0, DEPTH_C});
    imem_req  = can_fetch & (fetch_pc_q[1:0] == 2'b00);
    imem_addr = fetch_pc_q;
    adel_push = can_fetch & (fetch_pc_q[1:0] != 2'b00);
    resp_push = imem_rvalid & inflight_q;
    push      = resp_push | adel_push;
    dec_valid = reset_n & (count_q != '0);
    pop       = dec_valid & dec_ready;
    dec_instr = reset_n ? instr_q[rd_ptr_q] : '0;
    dec_pc    = reset_n ? pc_q[rd_ptr_q] : '0;
    dec_adel  = reset_n & adel_q[rd_ptr_q];
  end
  // Next state: advance fetch, push responses or an address-error entry, pop; redirect flushes all
  always_comb begin
    fetch_pc_d = imem_req ? fetch_pc_q + 32'd4 : fetch_pc_q;
    req_pc_d   = imem_req ? fetch_pc_q : req_pc_q;
    inflight_d = imem_req;
    halt_d     = halt_q | adel_push;
    instr_d    = instr_q;
    pc_d       = pc_q;
    adel_d     = adel_q;
    wr_ptr_d   = wr_ptr_q + PW'(push);
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    count_d    = count_q + CW'(push) - CW'(pop);
    if (push) begin
      instr_d[wr_ptr_q] = resp_push ? imem_rdata : '0;
      pc_d[wr_ptr_q]    = resp_push ? req_pc_q : fetch_pc_q;
      adel_d[wr_ptr_q]  = ~resp_push;
    end
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      inflight_d = 1'b0;
      halt_d     = 1'b0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end
  end
  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      halt_q     <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
        adel_q[i]  <= 1'b0;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      halt_q     <= halt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      adel_q     <= adel_d;
    end
  end
  // Occupancy can never exceed the FIFO size
  always_ff @(posedge clk) if (reset_n) assert (count_q <= DEPTH_C);
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed scenarios plus random traffic against a queue-based fetch model
module tb_fetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
  typedef struct packed {logic [31:0] instr; logic [31:0] pc; logic adel;} ent_t;
  logic        clk, reset_n, imem_req, imem_rvalid, redirect, dec_valid, dec_ready, dec_adel;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, dec_instr, dec_pc;
  int          checks, failures, nreq;
  ent_t        mq[$];
  logic [31:0] m_pc, m_req_pc, pend_addr, obs_pc, obs_addr;
  logic        m_inflight, m_halt, pend, obs_valid, obs_req;
  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset_n(reset_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_instr(dec_instr), .dec_pc(dec_pc), .dec_adel(dec_adel)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step(input logic rn, input logic rd, input logic [31:0] rpc, input logic rdy,
                      input logic spur);
    logic e_req, e_adel, e_valid;
    ent_t e;
    @(negedge clk);
    reset_n     = rn;
    redirect    = rd;
    redirect_pc = rpc;
    dec_ready   = rdy;
    imem_rvalid = pend | spur;
    imem_rdata  = pend ? (pend_addr ^ 32'hFFFF_FFFF) : $urandom();
    #1;
    e_req   = rn && !rd && !m_halt && m_pc[1:0] == 2'b00 && (mq.size() + int'(m_inflight) < DEPTH);
    e_adel  = rn && !rd && !m_halt && m_pc[1:0] != 2'b00 && (mq.size() + int'(m_inflight) < DEPTH);
    e_valid = rn && mq.size() != 0;
    check("imem_req", imem_req, e_req);
    if (e_req) check("imem_addr", imem_addr, m_pc);
    check("dec_valid", dec_valid, e_valid);
    if (e_valid) begin
      check("dec_pc", dec_pc, mq[0].pc);
      check("dec_instr", dec_instr, mq[0].instr);
      check("dec_adel", dec_adel, mq[0].adel);
    end
    if (!rn) begin
      check("rst_instr", dec_instr, 32'h0);
      check("rst_pc", dec_pc, 32'h0);
      check("rst_adel", dec_adel, 1'b0);
    end
    obs_valid = dec_valid;
    obs_pc    = dec_pc;
    obs_addr  = imem_addr;
    obs_req   = imem_req;
    if (imem_req) nreq++;
    pend      = imem_req;
    pend_addr = imem_addr;
    if (!rn) begin
      mq.delete();
      m_pc = RESET_PC;
      m_inflight = 1'b0;
      m_halt = 1'b0;
    end else if (rd) begin
      mq.delete();
      m_pc = rpc;
      m_inflight = 1'b0;
      m_halt = 1'b0;
    end else begin
      if (e_valid && rdy) void'(mq.pop_front());
      if (imem_rvalid && m_inflight) begin
        e.instr = imem_rdata; e.pc = m_req_pc; e.adel = 1'b0;
        mq.push_back(e);
      end else if (e_adel) begin
        e.instr = 32'h0; e.pc = m_pc; e.adel = 1'b1;
        mq.push_back(e);
        m_halt = 1'b1;
      end
      m_inflight = e_req;
      if (e_req) begin
        m_req_pc = m_pc;
        m_pc = m_pc + 32'd4;
      end
    end
  endtask
  initial begin
    logic [31:0] rpc;
    checks = 0; failures = 0; nreq = 0; pend = 1'b0; pend_addr = '0;
    reset_n = 1'b0; redirect = 1'b0; redirect_pc = '0; dec_ready = 1'b1;
    imem_rvalid = 1'b0; imem_rdata = '0;
    m_pc = RESET_PC; m_req_pc = '0; m_inflight = 1'b0; m_halt = 1'b0;
    repeat (2) step(0, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0);
    check("first_addr", obs_addr, RESET_PC);
    repeat (20) step(1, 0, 0, 1, 0);
    step(1, 1, 32'h0000_1000, 0, 0);
    nreq = 0;
    repeat (10) step(1, 0, 0, 0, 0);
    check("stall_reqs", nreq, 4);
    repeat (10) step(1, 0, 0, 1, 0);
    step(1, 1, 32'h8000_0100, 1, 0);
    step(1, 0, 0, 1, 0);
    check("redir_r1_valid", obs_valid, 1'b0);
    step(1, 0, 0, 1, 0);
    check("redir_r2_valid", obs_valid, 1'b0);
    step(1, 0, 0, 1, 0);
    check("redir_r3_valid", obs_valid, 1'b1);
    check("redir_r3_pc", obs_pc, 32'h8000_0100);
    repeat (5) step(1, 0, 0, 1, 0);
    step(1, 1, 32'h8000_0102, 0, 0);
    nreq = 0;
    repeat (4) step(1, 0, 0, 0, 0);
    repeat (4) step(1, 0, 0, 1, 0);
    check("adel_reqs", nreq, 0);
    step(1, 1, 32'h8000_0200, 1, 0);
    repeat (6) step(1, 0, 0, 1, 0);
    step(1, 1, 32'hFFFF_FFF8, 1, 0);
    repeat (8) step(1, 0, 0, 1, 0);
    repeat (8) step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0);
    check("post_rst_valid", obs_valid, 1'b0);
    check("post_rst_req", obs_req, 1'b1);
    check("post_rst_addr", obs_addr, RESET_PC);
    repeat (5) step(1, 0, 0, 1, 0);
    step(1, 1, 32'h8000_0400, 1, 0);
    step(1, 0, 0, 1, 0);
    check("redir_pop_valid", obs_valid, 1'b0);
    repeat (6) step(1, 0, 0, 1, 0);
    for (int i = 0; i < 3000; i++) begin
      rpc = $urandom();
      if ($urandom_range(0, 9) != 0) rpc[1:0] = 2'b00;
      step($urandom_range(0, 199) != 0, $urandom_range(0, 19) == 0, rpc,
           $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
